jk_excitation_drv: RTL

Synthesizable driver for a downstream JK flip-flop. It accepts a stream of target Q values over a valid/ready handshake and derives the J/K excitation from an internal model of the flip-flop's current state. It then checks the flip-flop's returned Q one cycle later and accumulates mismatch statistics. It is the stimulus and checking end of the JK flip-flop interface and replaces hand-written J/K sequencing in bring-up and self-test logic.

---
 rtl/jk_excitation_drv_if.sv | 28 ++
 rtl/jk_excitation_drv.sv | 118 +++++++++++
 2 files changed

// File: rtl/jk_excitation_drv_if.sv
// Target/check bus between a JK excitation driver and its user.
// Carries the target handshake, the returned flip-flop Q, the J/K drives and the check statistics.
interface jk_excitation_drv_if #(
  parameter int ERR_W = 8,
  parameter int CNT_W = 16
);
  logic             tgt_valid;
  logic             tgt_bit;
  logic             tgt_ready;
  logic             q_in;
  logic             j;
  logic             k;
  logic             chk_valid;
  logic             chk_ok;
  logic             err_flag;
  logic [ERR_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output tgt_valid, tgt_bit, q_in,
    input  tgt_ready, j, k, chk_valid, chk_ok, err_flag, err_cnt, bit_cnt
  );

  modport slave (
    input  tgt_valid, tgt_bit, q_in,
    output tgt_ready, j, k, chk_valid, chk_ok, err_flag, err_cnt, bit_cnt
  );
endinterface

// File: rtl/jk_excitation_drv.sv
// JK flip-flop excitation driver: derives J/K from a model of Q, then checks the returned Q.
// Define JK_DRV_RESYNC_EN to resynchronise the model to the observed Q after a mismatch.
module jk_excitation_drv #(
  parameter int DC_POLICY = 0,
  parameter int ERR_W     = 8,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  jk_excitation_drv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

  state_t           state_q, state_d;
  logic             qm_q, qm_d;
  logic             tgt_q, tgt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             chk_valid_q, chk_valid_d;
  logic             chk_ok_q, chk_ok_d;
  logic             err_flag_q, err_flag_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             match;

  // Don't-care positions take the DC_POLICY value; returns {J, K}.
  function automatic logic [1:0] excite(input logic qm, input logic tgt);
    logic dc;
    dc = (DC_POLICY != 0);
    if (!qm) excite = {tgt, dc};
    else     excite = {dc, ~tgt};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    sat_inc = (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign match = (bus.q_in == tgt_q);

  always_comb begin
    state_d     = state_q;
    qm_d        = qm_q;
    tgt_d       = tgt_q;
    j_d         = 1'b0;
    k_d         = 1'b0;
    chk_valid_d = 1'b0;
    chk_ok_d    = chk_ok_q;
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d      = bus.tgt_bit;
          {j_d, k_d} = excite(qm_q, bus.tgt_bit);
          state_d    = APPLY;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        chk_valid_d = 1'b1;
        chk_ok_d    = match;
        bit_cnt_d   = bit_cnt_q + 1'b1;
        if (!match) begin
          err_cnt_d  = sat_inc(err_cnt_q);
          err_flag_d = 1'b1;
        end
`ifdef JK_DRV_RESYNC_EN
        qm_d = match ? tgt_q : bus.q_in;
`else
        qm_d = tgt_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      qm_q        <= 1'b0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_ok_q    <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      qm_q        <= qm_d;
      j_q         <= j_d;
      k_q         <= k_d;
      chk_valid_q <= chk_valid_d;
      chk_ok_q    <= chk_ok_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  // The latched target is only read in CHECK after an accept, so it needs no reset.
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end

  assign bus.tgt_ready = (state_q == IDLE);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.chk_valid = chk_valid_q;
  assign bus.chk_ok    = chk_ok_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.bit_cnt   = bit_cnt_q;

endmodule
